i2c_reg_seq: RTL and testbench

- Transaction sequencer sitting directly upstream of the byte-level I2C master; drives its command interface (cmd, din, wr pulse) and consumes its ready, done_tick, ack and dout.
- Converts one register-access request into the full I2C command sequence for a single-byte register write or read:
  - Write: START, {dev,0}, reg, data, STOP.
  - Read: START, {dev,0}, reg, RESTART, {dev,1}, data with NACK, STOP.
- Returns read data and a NACK error flag through a one-cycle response strobe.

---
 rtl/i2c_pkg.sv | 50 +++++
 rtl/i2c_reg_seq.sv | 198 +++++++++++++++++++
 tb/tb_i2c_reg_seq.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master command codes, the read-NACK byte, the
// register-sequencer phase/sub-step enums and the phase-to-command mapping.
package i2c_pkg;

    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WR      = 3'b001;
    localparam logic [2:0] CMD_RD      = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_RESTART = 3'b100;

    // Bit0 = 1 tells the master to NACK the byte it is about to read.
    localparam logic [7:0] RD_NACK_BYTE = 8'hFF;

    typedef enum logic [3:0] {
        PH_IDLE,
        PH_START,
        PH_ADDR_W,
        PH_REG,
        PH_WDATA,
        PH_RESTART,
        PH_ADDR_R,
        PH_RDATA,
        PH_STOP,
        PH_RESP
    } phase_e;

    typedef enum logic {
        SUB_ISSUE,
        SUB_WAIT
    } sub_e;

    function automatic logic [2:0] cmd_for_phase(input phase_e ph);
        case (ph)
            PH_RESTART: return CMD_RESTART;
            PH_STOP:    return CMD_STOP;
            PH_RDATA:   return CMD_RD;
            PH_ADDR_W,
            PH_REG,
            PH_WDATA,
            PH_ADDR_R:  return CMD_WR;
            default:    return CMD_START;
        endcase
    endfunction

    function automatic logic is_byte_phase(input phase_e ph);
        return (ph == PH_ADDR_W) || (ph == PH_REG) || (ph == PH_WDATA) ||
               (ph == PH_ADDR_R) || (ph == PH_RDATA);
    endfunction

endpackage

// File: rtl/i2c_reg_seq.sv
// Register-access sequencer in front of the byte-level I2C master.
// Turns one request into START/addr/reg/data/STOP (write) or
// START/addr/reg/RESTART (or STOP+START)/addr/data-NACK/STOP (read) and
// returns read data plus a NACK error flag via a one-cycle response strobe.
// Ports:
//   clk_i, rst_i (async, active-high)
//   req_*   : request handshake (valid/ready), rnw, dev, reg, wdata
//   rsp_*   : one-cycle response strobe, read data, nack flag
//   m_*_o   : master command interface (cmd, din, wr strobe)
//   m_*_i   : master status (ready, done_tick, ack, dout)
module i2c_reg_seq
    import i2c_pkg::*;
#(
    parameter int USE_RESTART = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rnw_i,
    input  logic [6:0] req_dev_i,
    input  logic [7:0] req_reg_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_nack_o,
    output logic [2:0] m_cmd_o,
    output logic [7:0] m_din_o,
    output logic       m_wr_o,
    input  logic       m_ready_i,
    input  logic       m_done_tick_i,
    input  logic       m_ack_i,
    input  logic [7:0] m_dout_i
);

    phase_e     phase_q, phase_d;
    sub_e       sub_q, sub_d;
    logic       rnw_q, rnw_d;
    logic [6:0] dev_q, dev_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;
    logic       second_q, second_d;   // next START is the read-phase START (no-restart mode)
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_nack_q, rsp_nack_d;
    logic [2:0] m_cmd_q, m_cmd_d;
    logic [7:0] m_din_q, m_din_d;
    logic       m_wr_q, m_wr_d;
    logic       byte_ph;
    logic       step_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q     <= PH_IDLE;
            sub_q       <= SUB_ISSUE;
            rnw_q       <= 1'b0;
            dev_q       <= 7'd0;
            reg_q       <= 8'd0;
            wdata_q     <= 8'd0;
            rdata_q     <= 8'd0;
            err_q       <= 1'b0;
            second_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
            rsp_nack_q  <= 1'b0;
            m_cmd_q     <= CMD_START;
            m_din_q     <= 8'd0;
            m_wr_q      <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            sub_q       <= sub_d;
            rnw_q       <= rnw_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            second_q    <= second_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_nack_q  <= rsp_nack_d;
            m_cmd_q     <= m_cmd_d;
            m_din_q     <= m_din_d;
            m_wr_q      <= m_wr_d;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        sub_d       = sub_q;
        rnw_d       = rnw_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        second_d    = second_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_nack_d  = rsp_nack_q;
        m_cmd_d     = m_cmd_q;
        m_din_d     = m_din_q;
        m_wr_d      = 1'b0;
        byte_ph     = is_byte_phase(phase_q);
        // The strobe is registered, so the master only reacts one cycle after
        // m_wr_q rises; ignore status while our own strobe is still on the wire.
        step_done   = (sub_q == SUB_WAIT) && !m_wr_q &&
                      (byte_ph ? m_done_tick_i : m_ready_i);

        case (phase_q)
            PH_IDLE: begin
                if (req_valid_i) begin
                    rnw_d    = req_rnw_i;
                    dev_d    = req_dev_i;
                    reg_d    = req_reg_i;
                    wdata_d  = req_wdata_i;
                    rdata_d  = 8'd0;
                    err_d    = 1'b0;
                    second_d = 1'b0;
                    phase_d  = PH_START;
                    sub_d    = SUB_ISSUE;
                end
            end
            PH_RESP: phase_d = PH_IDLE;
            default: begin
                if (sub_q == SUB_ISSUE) begin
                    if (m_ready_i) begin
                        m_wr_d  = 1'b1;
                        sub_d   = SUB_WAIT;
                        m_cmd_d = cmd_for_phase(phase_q);
                        case (phase_q)
                            PH_ADDR_W: m_din_d = {dev_q, 1'b0};
                            PH_REG:    m_din_d = reg_q;
                            PH_WDATA:  m_din_d = wdata_q;
                            PH_ADDR_R: m_din_d = {dev_q, 1'b1};
                            PH_RDATA:  m_din_d = RD_NACK_BYTE;
                            default:   m_din_d = m_din_q;
                        endcase
                    end
                end else if (step_done) begin
                    sub_d = SUB_ISSUE;
                    case (phase_q)
                        PH_START: begin
                            phase_d  = second_q ? PH_ADDR_R : PH_ADDR_W;
                            second_d = 1'b0;
                        end
                        PH_ADDR_W: phase_d = PH_REG;
                        PH_REG: begin
                            if (!rnw_q) begin
                                phase_d = PH_WDATA;
                            end else if (USE_RESTART != 0) begin
                                phase_d = PH_RESTART;
                            end else begin
                                phase_d  = PH_STOP;
                                second_d = 1'b1;
                            end
                        end
                        PH_WDATA:   phase_d = PH_STOP;
                        PH_RESTART: phase_d = PH_ADDR_R;
                        PH_ADDR_R:  phase_d = PH_RDATA;
                        PH_RDATA: begin
                            rdata_d = m_dout_i;
                            phase_d = PH_STOP;
                        end
                        PH_STOP: begin
                            if (second_q) begin
                                phase_d = PH_START;
                            end else begin
                                phase_d     = PH_RESP;
                                rsp_valid_d = 1'b1;
                                rsp_rdata_d = err_q ? 8'd0 : rdata_q;
                                rsp_nack_d  = err_q;
                            end
                        end
                        default: phase_d = PH_IDLE;
                    endcase
                    // Slave NACK on any written byte aborts straight to STOP.
                    if (byte_ph && (phase_q != PH_RDATA) && m_ack_i) begin
                        err_d    = 1'b1;
                        second_d = 1'b0;
                        phase_d  = PH_STOP;
                    end
                end
            end
        endcase
    end

    assign req_ready_o = (phase_q == PH_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_nack_o  = rsp_nack_q;
    assign m_cmd_o     = m_cmd_q;
    assign m_din_o     = m_din_q;
    assign m_wr_o      = m_wr_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: two instances (repeated-start and stop/start modes)
// share a behavioural master+slave model; a mux selects the active one.
module tb_i2c_reg_seq;
    import i2c_pkg::*;

    localparam logic [6:0] SLAVE_ADDR = 7'h50;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       req_valid_i = 1'b0;
    logic       req_rnw_i = 1'b0;
    logic [6:0] req_dev_i = 7'd0;
    logic [7:0] req_reg_i = 8'd0;
    logic [7:0] req_wdata_i = 8'd0;
    logic       m_ready_i, m_done_tick_i, m_ack_i;
    logic [7:0] m_dout_i;
    logic       sel = 1'b0;   // 0: USE_RESTART=1 instance, 1: USE_RESTART=0 instance
    logic [7:0] slave_rdata = 8'd0;

    logic       rdy1, rv1, nk1, wr1, rdy0, rv0, nk0, wr0;
    logic [7:0] rd1, din1, rd0, din0;
    logic [2:0] cmd1, cmd0;
    logic       vld1, vld0;

    assign vld1 = req_valid_i & ~sel;
    assign vld0 = req_valid_i & sel;

    i2c_reg_seq #(.USE_RESTART(1)) dut_r1 (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(vld1), .req_ready_o(rdy1),
        .req_rnw_i(req_rnw_i), .req_dev_i(req_dev_i), .req_reg_i(req_reg_i),
        .req_wdata_i(req_wdata_i), .rsp_valid_o(rv1), .rsp_rdata_o(rd1),
        .rsp_nack_o(nk1), .m_cmd_o(cmd1), .m_din_o(din1), .m_wr_o(wr1),
        .m_ready_i(m_ready_i), .m_done_tick_i(m_done_tick_i), .m_ack_i(m_ack_i),
        .m_dout_i(m_dout_i));

    i2c_reg_seq #(.USE_RESTART(0)) dut_r0 (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(vld0), .req_ready_o(rdy0),
        .req_rnw_i(req_rnw_i), .req_dev_i(req_dev_i), .req_reg_i(req_reg_i),
        .req_wdata_i(req_wdata_i), .rsp_valid_o(rv0), .rsp_rdata_o(rd0),
        .rsp_nack_o(nk0), .m_cmd_o(cmd0), .m_din_o(din0), .m_wr_o(wr0),
        .m_ready_i(m_ready_i), .m_done_tick_i(m_done_tick_i), .m_ack_i(m_ack_i),
        .m_dout_i(m_dout_i));

    logic       rdy, rv, nk, m_wr, oth_rdy, oth_rv;
    logic [7:0] rd, m_din;
    logic [2:0] m_cmd;
    assign rdy     = sel ? rdy0 : rdy1;
    assign rv      = sel ? rv0  : rv1;
    assign nk      = sel ? nk0  : nk1;
    assign rd      = sel ? rd0  : rd1;
    assign m_wr    = sel ? wr0  : wr1;
    assign m_cmd   = sel ? cmd0 : cmd1;
    assign m_din   = sel ? din0 : din1;
    assign oth_rdy = sel ? rdy1 : rdy0;
    assign oth_rv  = sel ? rv1  : rv0;

    always #5 clk_i = ~clk_i;

    // Behavioural master + slave: each strobe takes 3 busy cycles; byte
    // commands end with a done tick carrying the slave (or master) ACK bit.
    logic [2:0] log_cmd[$];
    logic [7:0] log_din[$];
    logic [3:0] mcnt;
    logic [2:0] mcmd;
    logic [7:0] mdin;
    logic       sl_addr_ph, sl_sel;
    int         wr_viol = 0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_ready_i     <= 1'b1;
            m_done_tick_i <= 1'b0;
            m_ack_i       <= 1'b0;
            m_dout_i      <= 8'd0;
            mcnt          <= 4'd0;
            mcmd          <= CMD_START;
            mdin          <= 8'd0;
            sl_addr_ph    <= 1'b0;
            sl_sel        <= 1'b0;
        end else begin
            m_done_tick_i <= 1'b0;
            if (mcnt != 4'd0) begin
                mcnt <= mcnt - 4'd1;
                if (mcnt == 4'd1) begin
                    m_ready_i <= 1'b1;
                    case (mcmd)
                        CMD_START, CMD_RESTART: sl_addr_ph <= 1'b1;
                        CMD_STOP: begin
                            sl_addr_ph <= 1'b0;
                            sl_sel     <= 1'b0;
                        end
                        CMD_WR: begin
                            m_done_tick_i <= 1'b1;
                            if (sl_addr_ph) begin
                                sl_sel     <= (mdin[7:1] == SLAVE_ADDR);
                                m_ack_i    <= (mdin[7:1] != SLAVE_ADDR);
                                sl_addr_ph <= 1'b0;
                            end else begin
                                m_ack_i <= ~sl_sel;
                            end
                        end
                        CMD_RD: begin
                            m_done_tick_i <= 1'b1;
                            m_dout_i      <= slave_rdata;
                            m_ack_i       <= mdin[0];
                        end
                        default: ;
                    endcase
                end
            end else if (m_wr && m_ready_i) begin
                m_ready_i <= 1'b0;
                mcnt      <= 4'd3;
                mcmd      <= m_cmd;
                mdin      <= m_din;
                log_cmd.push_back(m_cmd);
                log_din.push_back(m_din);
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i && ((wr1 && !m_ready_i) || (wr0 && !m_ready_i)))
            wr_viol <= wr_viol + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic             sel;
        logic             rnw;
        logic [6:0]       dev;
        logic [7:0]       rg;
        logic [7:0]       wd;
        logic [7:0]       srd;
        int               n;
        logic [7:0][2:0]  cmd;
        logic [7:0][7:0]  din;
        logic [7:0]       rdata;
        logic             nack;
    } vec_t;

    vec_t tbl[5];

    task automatic set_vec(input int v, input logic s, input logic r, input logic [6:0] d,
                           input logic [7:0] g, input logic [7:0] w, input logic [7:0] srd,
                           input logic [7:0] erd, input logic en);
        tbl[v].sel = s; tbl[v].rnw = r; tbl[v].dev = d; tbl[v].rg = g; tbl[v].wd = w;
        tbl[v].srd = srd; tbl[v].rdata = erd; tbl[v].nack = en; tbl[v].n = 0;
        tbl[v].cmd = '0; tbl[v].din = '0;
    endtask

    task automatic add(input int v, input logic [2:0] c, input logic [7:0] d);
        tbl[v].cmd[tbl[v].n] = c;
        tbl[v].din[tbl[v].n] = d;
        tbl[v].n++;
    endtask

    task automatic wait_rsp(input string name);
        int c = 0;
        while (!rv && c < 3000) begin
            @(negedge clk_i);
            c++;
        end
        check({name, "_rsp_timeout"}, 32'(c < 3000), 32'd1);
    endtask

    task automatic check_log(input int v, input int base);
        check($sformatf("v%0d_nstrobes", v), 32'(log_cmd.size()), 32'(base + tbl[v].n));
        for (int k = 0; k < tbl[v].n; k++) begin
            if (base + k < log_cmd.size()) begin
                check($sformatf("v%0d_cmd%0d", v, k), 32'(log_cmd[base + k]), 32'(tbl[v].cmd[k]));
                if (tbl[v].cmd[k] == CMD_WR || tbl[v].cmd[k] == CMD_RD)
                    check($sformatf("v%0d_din%0d", v, k), 32'(log_din[base + k]), 32'(tbl[v].din[k]));
            end
        end
    endtask

    task automatic drive_req(input int v);
        req_rnw_i   = tbl[v].rnw;
        req_dev_i   = tbl[v].dev;
        req_reg_i   = tbl[v].rg;
        req_wdata_i = tbl[v].wd;
    endtask

    task automatic run_vec(input int v);
        @(negedge clk_i);
        sel         = tbl[v].sel;
        slave_rdata = tbl[v].srd;
        log_cmd.delete();
        log_din.delete();
        drive_req(v);
        req_valid_i = 1'b1;
        @(negedge clk_i);
        check($sformatf("v%0d_ready_drop", v), 32'(rdy), 32'd0);
        req_valid_i = 1'b0;
        wait_rsp($sformatf("v%0d", v));
        check($sformatf("v%0d_rdata", v), 32'(rd), 32'(tbl[v].rdata));
        check($sformatf("v%0d_nack", v), 32'(nk), 32'(tbl[v].nack));
        @(negedge clk_i);
        check($sformatf("v%0d_rsp_pulse", v), 32'(rv), 32'd0);
        check($sformatf("v%0d_ready_back", v), 32'(rdy), 32'd1);
        check($sformatf("v%0d_rdata_hold", v), 32'(rd), 32'(tbl[v].rdata));
        check($sformatf("v%0d_other_idle", v), 32'({oth_rdy, oth_rv}), 32'b10);
        check_log(v, 0);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_ready"}, 32'(rdy1 & rdy0), 32'd1);
        check({name, "_rsp"}, 32'({rv1, nk1, rd1, rv0, nk0, rd0}), 32'd0);
        check({name, "_mwr"}, 32'({wr1, wr0}), 32'd0);
        check({name, "_mcmd"}, 32'({cmd1, cmd0}), 32'({CMD_START, CMD_START}));
        check({name, "_mdin"}, 32'({din1, din0}), 32'd0);
    endtask

    initial begin
        // write ok
        set_vec(0, 1'b0, 1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 8'h00, 1'b0);
        add(0, CMD_START, 0); add(0, CMD_WR, 8'hA0); add(0, CMD_WR, 8'h10);
        add(0, CMD_WR, 8'hA5); add(0, CMD_STOP, 0);
        // read with repeated start
        set_vec(1, 1'b0, 1'b1, 7'h50, 8'h20, 8'h00, 8'h3C, 8'h3C, 1'b0);
        add(1, CMD_START, 0); add(1, CMD_WR, 8'hA0); add(1, CMD_WR, 8'h20);
        add(1, CMD_RESTART, 0); add(1, CMD_WR, 8'hA1); add(1, CMD_RD, 8'hFF);
        add(1, CMD_STOP, 0);
        // write to absent device
        set_vec(2, 1'b0, 1'b0, 7'h51, 8'h10, 8'h5A, 8'h00, 8'h00, 1'b1);
        add(2, CMD_START, 0); add(2, CMD_WR, 8'hA2); add(2, CMD_STOP, 0);
        // read with stop/start
        set_vec(3, 1'b1, 1'b1, 7'h50, 8'h05, 8'h00, 8'h99, 8'h99, 1'b0);
        add(3, CMD_START, 0); add(3, CMD_WR, 8'hA0); add(3, CMD_WR, 8'h05);
        add(3, CMD_STOP, 0); add(3, CMD_START, 0); add(3, CMD_WR, 8'hA1);
        add(3, CMD_RD, 8'hFF); add(3, CMD_STOP, 0);
        // read from absent device: rdata forced to 0
        set_vec(4, 1'b0, 1'b1, 7'h51, 8'h07, 8'h00, 8'h77, 8'h00, 1'b1);
        add(4, CMD_START, 0); add(4, CMD_WR, 8'hA2); add(4, CMD_STOP, 0);

        repeat (3) @(negedge clk_i);
        check_reset_vals("rst_held");
        rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_vals("rst_released");

        for (int v = 0; v < 5; v++) run_vec(v);

        // Back-to-back: valid held across two writes.
        @(negedge clk_i);
        sel = 1'b0;
        log_cmd.delete();
        log_din.delete();
        drive_req(0);
        req_valid_i = 1'b1;
        @(negedge clk_i);
        check("b2b_first_accept", 32'(rdy), 32'd0);
        wait_rsp("b2b_first");
        check("b2b_busy_at_rsp", 32'(rdy), 32'd0);
        @(negedge clk_i);
        check("b2b_ready_after_rsp", 32'(rdy), 32'd1);
        @(negedge clk_i);
        check("b2b_second_accept", 32'(rdy), 32'd0);
        req_valid_i = 1'b0;
        wait_rsp("b2b_second");
        check("b2b_nack", 32'(nk), 32'd0);
        @(negedge clk_i);
        check_log(0, 5);
        check("b2b_first_log", 32'({log_cmd[0], log_din[1]}), 32'({CMD_START, 8'hA0}));

        // Reset during the WDATA byte, then a clean write.
        @(negedge clk_i);
        log_cmd.delete();
        log_din.delete();
        drive_req(0);
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        for (int c = 0; c < 200 && log_cmd.size() < 4; c++) @(negedge clk_i);
        check("midrst_reached_wdata", 32'(log_cmd.size()), 32'd4);
        rst_i = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_ready_after", 32'(rdy), 32'd1);
        run_vec(0);

        check("no_strobe_while_busy", 32'(wr_viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
